// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART TX frame sequencer, serializer, parity calculator and output mux.
// Holds only constants; it adds no logic and no latency.
package uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Data-bit counter: clears, increments once per cycle and saturates at Data_Width-1.
// The count is registered, so a change is visible one cycle after clear or increment.
module uart_tx_bit_cnt #(
  parameter int Data_Width = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          i_clr,
  input  logic                          i_inc,
  output logic [$clog2(Data_Width)-1:0] o_cnt,
  output logic                          o_done
);

  localparam int            CW   = $clog2(Data_Width);
  localparam logic [CW-1:0] LAST = CW'(Data_Width - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer (Moore): start, Data_Width data bits, optional parity, stop.
// A request is taken only while Busy=0, so there is at least one idle cycle between frames.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int Data_Width = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Data_Valid,
  input  logic                          PAR_EN,
  output logic                          Ser_En,
  output logic [1:0]                    Mux_Sel,
  output logic [$clog2(Data_Width)-1:0] Bit_Idx,
  output logic                          Busy
);

  localparam int CW = $clog2(Data_Width);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic          r_par_en_q;
  logic          w_accept;
  logic          w_cnt_clr;
  logic          w_cnt_inc;
  logic          w_cnt_done;
  logic [CW-1:0] w_cnt;

  assign w_accept  = (r_state == ST_IDLE) && Data_Valid;
  assign w_cnt_clr = (r_state == ST_START);
  assign w_cnt_inc = (r_state == ST_DATA);

  uart_tx_bit_cnt #(
    .Data_Width (Data_Width)
  ) u_bit_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_cnt_inc),
    .o_cnt  (w_cnt),
    .o_done (w_cnt_done)
  );

  // Parity enable is frozen at acceptance so a mid-frame PAR_EN change cannot alter the frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_par_en_q <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_par_en_q <= PAR_EN;
      end
    end
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_next = w_accept ? ST_START : ST_IDLE;
      ST_START:  w_next = ST_DATA;
      ST_DATA:   w_next = w_cnt_done ? (r_par_en_q ? ST_PARITY : ST_STOP) : ST_DATA;
      ST_PARITY: w_next = ST_STOP;
      ST_STOP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    Mux_Sel = MUX_STOP;
    Busy    = 1'b1;
    Ser_En  = 1'b0;
    Bit_Idx = '0;
    case (r_state)
      ST_START:  Mux_Sel = MUX_START;
      ST_DATA: begin
        Mux_Sel = MUX_DATA;
        Ser_En  = 1'b1;
        Bit_Idx = w_cnt;
      end
      ST_PARITY: Mux_Sel = MUX_PAR;
      ST_STOP:   Mux_Sel = MUX_STOP;
      default:   Busy    = 1'b0;
    endcase
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame sequencer for the UART transmitter. It accepts a transmit request and steps the TX datapath through start, data, optional parity and stop bits. It drives the serializer shift enable, the output-mux select and the Busy flag; the serializer and parity calculator load P_DATA themselves on `Data_Valid && !Busy`. One controller instance sits beside one serializer, one parity calculator and one output mux per UART TX.

## Interface
- `Data_Width`, default 8: data bits per frame (≥2).
- `CLK`  input  1: clock; one TX bit time per cycle (baud clock).
- `RST`  input  1: reset, asynchronous, active-low.
- `Data_Valid`  input  1: transmit request; honoured only while `Busy`=0.
- `PAR_EN`  input  1: parity bit enable, sampled at request acceptance.
- `Ser_En`  output  1: serializer shift enable, high for each data bit.
- `Mux_Sel`  output  2: output mux select: 00 start (0), 01 stop/idle (1), 10 serial data, 11 parity bit.
- `Bit_Idx`  output  $clog2(Data_Width): index of the data bit currently driven (debug/verification).
- `Busy`  output  1: frame in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Registered state; all outputs decode from registered state/counter only (Moore).
- Transitions:
  - IDLE → START when `Data_Valid`=1 (acceptance); latch `PAR_EN` into `par_en_q`.
  - START → DATA, clear bit counter.
  - DATA: counter +1 per cycle; on counter = `Data_Width`-1 → PARITY if `par_en_q`, else STOP.
  - PARITY → STOP.
  - STOP → IDLE, unconditionally.
- Outputs per state:
  - IDLE: `Mux_Sel`=01, `Busy`=0, `Ser_En`=0.
  - START: `Mux_Sel`=00, `Busy`=1.
  - DATA: `Mux_Sel`=10, `Ser_En`=1, `Busy`=1, `Bit_Idx`=counter.
  - PARITY: `Mux_Sel`=11, `Busy`=1.
  - STOP: `Mux_Sel`=01, `Busy`=1.
- `Bit_Idx`=0 outside DATA. Counter does not wrap within a frame; it saturates at `Data_Width`-1 and clears in START.
- `Data_Valid` outside IDLE is ignored; it is not queued.
- A `PAR_EN` change mid-frame has no effect on the current frame.
- Illegal state encodings → IDLE on the next edge.

## Timing
- Reset (`RST`=0, any time, including mid-frame): state IDLE, `Busy`=0, `Ser_En`=0, `Mux_Sel`=01, `Bit_Idx`=0, `par_en_q`=0. Line returns to idle-high immediately; the partial frame is abandoned.
- `Data_Valid` sampled high in IDLE at edge t → START visible after t, `Busy`=1 from t.
- Frame occupancy: `Busy` high for 1+`Data_Width`+`par_en_q`+1 cycles (10 or 11 for `Data_Width`=8). `Ser_En` high for exactly `Data_Width` consecutive cycles starting 1 cycle after START.
- Parity-bit validity: the parity calculator registers data at acceptance and parity one cycle later. PARITY is reached ≥ `Data_Width`+1 cycles after acceptance, so `PAR_Bit` is stable there.
- Minimum inter-frame gap: one IDLE cycle (`Busy`=0), since acceptance requires `Busy`=0. `Data_Valid` held high continuously yields frames separated by exactly one IDLE cycle.

## Structure
- Shared package `uart_tx_pkg`:
  - state enum encodings;
  - `Mux_Sel` constants `MUX_START`=00, `MUX_STOP`=01, `MUX_DATA`=10, `MUX_PAR`=11.
  - Parity and serializer blocks use the same constants.
- One natural sub-module: `uart_tx_bit_cnt` (clear, increment, done at `Data_Width`-1, saturating). Everything else stays in the FSM.

## Test plan
- Reset then idle: `RST` low 3 cycles, release, `Data_Valid`=0 for 5 cycles → `Mux_Sel`=01, `Busy`=0, `Ser_En`=0 throughout.
- Frame without parity: `PAR_EN`=0, pulse `Data_Valid` one cycle → `Mux_Sel` sequence 00, 10×8, 01, then 01 idle; `Busy` high for 10 cycles; `Bit_Idx` 0..7 during `Ser_En`.
- Frame with parity: `PAR_EN`=1 → sequence 00, 10×8, 11, 01; `Busy` high 11 cycles. Drop `PAR_EN` to 0 in cycle 3 → parity cycle still present.
- Back-to-back: `Data_Valid` held high for 30 cycles with `PAR_EN`=0 → frames of 10 `Busy` cycles separated by exactly 1 `Busy`=0 cycle. Extra `Data_Valid` during `Busy` is not counted.
- Reset mid-frame: assert `RST` low during DATA at `Bit_Idx`=4 → same cycle `Busy`=0, `Mux_Sel`=01, `Ser_En`=0. After release, new request → full fresh frame starting with `Bit_Idx`=0.
- `Data_Width`=5 build: `PAR_EN`=1 → `Ser_En` high 5 cycles, `Busy` 8 cycles, `Bit_Idx` 0..4.
